// File: rtl/multicycle_control_fsm.sv
// Sequencer for the shared-ALU, shared-memory multi-cycle MIPS datapath.
// Define ILLEGAL_OP_TRAP_EN to trap unknown opcodes into HALT.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       BusErr,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       buserr_q;
  logic       in_mem, mem_wait, tmo_hit;

  assign in_mem   = (state_q == FETCH) ||
                    (state_q == MEMREAD) ||
                    (state_q == MEMWRITE);
  assign mem_wait = in_mem && !MemReady;
  assign tmo_hit  = mem_wait && (cnt_q == TMO);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:    if (MemReady) state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          (Opcode == OP_LW),
          (Opcode == OP_SW):   state_d = MEMADR;
          (Opcode == OP_RTYP): state_d = EXECUTE;
          (Opcode == OP_BEQ):  state_d = BRANCH;
          (Opcode == OP_ADDI): state_d = ADDIEXEC;
          (Opcode == OP_J):    state_d = JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:             state_d = HALT;
`else
          default:             state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = (Opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (MemReady) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (MemReady) state_d = FETCH;
      EXECUTE:  state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      ADDIEXEC: state_d = ADDIWB;
      ADDIWB:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
    // A timed-out access is abandoned and the instruction refetched.
    if (tmo_hit) state_d = FETCH;
  end

  always_comb begin
    if (state_d != state_q || tmo_hit) cnt_d = 8'd0;
    else if (mem_wait)                 cnt_d = cnt_q + 8'd1;
    else                               cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      cnt_q    <= 8'd0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buserr_q <= tmo_hit;
    end
  end

  always_comb begin
    MemReq     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b010;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    unique case (state_q)
      FETCH: begin
        MemReq  = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE:   ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMREAD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWRITE: begin
        MemReq   = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        unique case (Funct)
          6'b100010: ALUControl = 3'b100;
          6'b101010: ALUControl = 3'b110;
          6'b011100: ALUControl = 3'b101;
          default:   ALUControl = 3'b010;
        endcase
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b100;
        PCSrc      = 2'b01;
        Branch     = 1'b1;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB:   RegWrite = 1'b1;
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      HALT:     MemReq = 1'b0;
      default:  MemReq = 1'b0;
    endcase
  end

  assign BusErr = buserr_q;
  assign State  = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed vector bench for multicycle_control_fsm.
// Build with +define+ILLEGAL_OP_TRAP_EN to exercise the HALT trap.
module tb_multicycle_control_fsm;

  localparam int TMO = 15;

  logic       clk, rst;
  logic [5:0] Opcode, Funct;
  logic       MemReady;
  logic       MemReq, IorD, MemWrite, IRWrite, PCWrite, Branch;
  logic [1:0] PCSrc, ALUSrcB;
  logic       ALUSrcA, RegDst, MemtoReg, RegWrite, BusErr;
  logic [2:0] ALUControl;
  logic [3:0] State;

  multicycle_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .Opcode(Opcode), .Funct(Funct), .MemReady(MemReady),
    .MemReq(MemReq), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .BusErr(BusErr), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {MemReq,IorD,MemWrite,IRWrite,PCWrite,Branch}, PCSrc, ALUSrcA,
  // ALUSrcB, ALUControl, {RegDst,MemtoReg,RegWrite,BusErr}
  localparam logic [17:0] O_FETCH  = {6'b100000, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000};
  localparam logic [17:0] O_FETCHR = {6'b100110, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000};
  localparam logic [17:0] O_BUSERR = {6'b100000, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0001};
  localparam logic [17:0] O_DEC    = {6'b000000, 2'b00, 1'b0, 2'b11, 3'b010, 4'b0000};
  localparam logic [17:0] O_MADR   = {6'b000000, 2'b00, 1'b1, 2'b10, 3'b010, 4'b0000};
  localparam logic [17:0] O_MRD    = {6'b110000, 2'b00, 1'b0, 2'b00, 3'b010, 4'b0000};
  localparam logic [17:0] O_MWB    = {6'b000000, 2'b00, 1'b0, 2'b00, 3'b010, 4'b0110};
  localparam logic [17:0] O_MWR    = {6'b111000, 2'b00, 1'b0, 2'b00, 3'b010, 4'b0000};
  localparam logic [17:0] O_EXA    = {6'b000000, 2'b00, 1'b1, 2'b00, 3'b010, 4'b0000};
  localparam logic [17:0] O_EXS    = {6'b000000, 2'b00, 1'b1, 2'b00, 3'b100, 4'b0000};
  localparam logic [17:0] O_EXN    = {6'b000000, 2'b00, 1'b1, 2'b00, 3'b110, 4'b0000};
  localparam logic [17:0] O_EXO    = {6'b000000, 2'b00, 1'b1, 2'b00, 3'b101, 4'b0000};
  localparam logic [17:0] O_AWB    = {6'b000000, 2'b00, 1'b0, 2'b00, 3'b010, 4'b1010};
  localparam logic [17:0] O_BR     = {6'b000001, 2'b01, 1'b1, 2'b00, 3'b100, 4'b0000};
  localparam logic [17:0] O_AIEX   = {6'b000000, 2'b00, 1'b1, 2'b10, 3'b010, 4'b0000};
  localparam logic [17:0] O_AIWB   = {6'b000000, 2'b00, 1'b0, 2'b00, 3'b010, 4'b0010};
  localparam logic [17:0] O_JMP    = {6'b000010, 2'b10, 1'b0, 2'b00, 3'b010, 4'b0000};
  localparam logic [17:0] O_HALT   = {6'b000000, 2'b00, 1'b0, 2'b00, 3'b010, 4'b0000};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] out;
  } vec_t;

  vec_t vecs[$];
  int   n_vec, n_bad;

  task automatic add(input logic r, input logic [5:0] op,
                     input logic [5:0] fn, input logic rdy,
                     input logic [3:0] st, input logic [17:0] o);
    vec_t v;
    v.r = r; v.op = op; v.fn = fn; v.rdy = rdy; v.st = st; v.out = o;
    vecs.push_back(v);
  endtask

  // Drive inputs just after posedge, compare at negedge, advance.
  task automatic cyc(input logic r, input logic [5:0] op,
                     input logic [5:0] fn, input logic rdy,
                     input logic [3:0] st, input logic [17:0] o,
                     input string tag);
    logic [17:0] act;
    rst = r; Opcode = op; Funct = fn; MemReady = rdy;
    @(negedge clk);
    act = {MemReq, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
           ALUSrcA, ALUSrcB, ALUControl, RegDst, MemtoReg,
           RegWrite, BusErr};
    n_vec++;
    if (State !== st || act !== o) begin
      n_bad++;
      $display("FAIL %s #%0d: got State=%0d out=%b, want State=%0d out=%b",
               tag, n_vec, State, act, st, o);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1; Opcode = RT; Funct = 6'b0; MemReady = 1'b0;

    add(0, RT, 6'b100000, 0, 0, O_FETCH);
    add(0, RT, 6'b100000, 1, 0, O_FETCHR);
    add(0, RT, 6'b100000, 1, 1, O_DEC);
    add(0, RT, 6'b100000, 1, 6, O_EXA);
    add(0, RT, 6'b100000, 1, 7, O_AWB);
    add(0, RT, 6'b100010, 1, 0, O_FETCHR);
    add(0, RT, 6'b100010, 1, 1, O_DEC);
    add(0, RT, 6'b100010, 1, 6, O_EXS);
    add(0, RT, 6'b100010, 1, 7, O_AWB);
    add(0, RT, 6'b101010, 1, 0, O_FETCHR);
    add(0, RT, 6'b101010, 1, 1, O_DEC);
    add(0, RT, 6'b101010, 1, 6, O_EXN);
    add(0, RT, 6'b101010, 1, 7, O_AWB);
    add(0, RT, 6'b011100, 1, 0, O_FETCHR);
    add(0, RT, 6'b011100, 1, 1, O_DEC);
    add(0, RT, 6'b011100, 1, 6, O_EXO);
    add(0, RT, 6'b011100, 1, 7, O_AWB);
    add(0, RT, 6'b111111, 1, 0, O_FETCHR);
    add(0, RT, 6'b111111, 1, 1, O_DEC);
    add(0, RT, 6'b111111, 1, 6, O_EXA);
    add(0, RT, 6'b111111, 1, 7, O_AWB);
    add(0, ADDI, 6'b0, 1, 0, O_FETCHR);
    add(0, ADDI, 6'b0, 1, 1, O_DEC);
    add(0, ADDI, 6'b0, 1, 9, O_AIEX);
    add(0, ADDI, 6'b0, 1, 10, O_AIWB);
    add(0, BEQ, 6'b0, 1, 0, O_FETCHR);
    add(0, BEQ, 6'b0, 1, 1, O_DEC);
    add(0, BEQ, 6'b0, 1, 8, O_BR);
    add(0, J, 6'b0, 1, 0, O_FETCHR);
    add(0, J, 6'b0, 1, 1, O_DEC);
    add(0, J, 6'b0, 1, 11, O_JMP);
    add(0, SW, 6'b0, 1, 0, O_FETCHR);
    add(0, SW, 6'b0, 1, 1, O_DEC);
    add(0, SW, 6'b0, 1, 2, O_MADR);
    add(0, SW, 6'b0, 1, 5, O_MWR);
    add(0, LW, 6'b0, 0, 0, O_FETCH);
    add(0, LW, 6'b0, 0, 0, O_FETCH);
    add(0, LW, 6'b0, 1, 0, O_FETCHR);
    add(0, LW, 6'b0, 1, 1, O_DEC);
    add(0, LW, 6'b0, 1, 2, O_MADR);
    add(0, LW, 6'b0, 0, 3, O_MRD);
    add(0, LW, 6'b0, 0, 3, O_MRD);
    add(0, LW, 6'b0, 0, 3, O_MRD);
    add(0, LW, 6'b0, 1, 3, O_MRD);
    add(0, LW, 6'b0, 1, 4, O_MWB);
    add(0, SW, 6'b0, 1, 0, O_FETCHR);
    add(0, SW, 6'b0, 1, 1, O_DEC);
    add(0, SW, 6'b0, 1, 2, O_MADR);
    add(0, SW, 6'b0, 0, 5, O_MWR);
    add(0, SW, 6'b0, 0, 5, O_MWR);
    add(0, SW, 6'b0, 1, 5, O_MWR);
`ifndef ILLEGAL_OP_TRAP_EN
    add(0, BAD, 6'b0, 1, 0, O_FETCHR);
    add(0, BAD, 6'b0, 1, 1, O_DEC);
    add(0, BAD, 6'b0, 0, 0, O_FETCH);
    add(0, BAD, 6'b0, 1, 0, O_FETCHR);
    add(0, BAD, 6'b0, 1, 1, O_DEC);
`endif

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++)
      cyc(vecs[i].r, vecs[i].op, vecs[i].fn, vecs[i].rdy,
          vecs[i].st, vecs[i].out, "table");

    for (int i = 0; i <= TMO; i++)
      cyc(0, RT, 6'b0, 0, 0, O_FETCH, "tmo_wait");
    cyc(0, RT, 6'b0, 0, 0, O_BUSERR, "tmo_buserr");
    cyc(0, RT, 6'b0, 0, 0, O_FETCH, "tmo_after");

    cyc(0, LW, 6'b0, 1, 0, O_FETCHR, "rdy_wins");
    cyc(0, LW, 6'b0, 1, 1, O_DEC, "rdy_wins");
    cyc(0, LW, 6'b0, 1, 2, O_MADR, "rdy_wins");
    for (int i = 0; i < TMO; i++)
      cyc(0, LW, 6'b0, 0, 3, O_MRD, "rdy_wins_wait");
    cyc(0, LW, 6'b0, 1, 3, O_MRD, "rdy_wins_last");
    cyc(0, LW, 6'b0, 1, 4, O_MWB, "rdy_wins_wb");
    cyc(0, LW, 6'b0, 0, 0, O_FETCH, "rdy_wins_noerr");

    cyc(0, SW, 6'b0, 1, 0, O_FETCHR, "rst_mw");
    cyc(0, SW, 6'b0, 1, 1, O_DEC, "rst_mw");
    cyc(0, SW, 6'b0, 1, 2, O_MADR, "rst_mw");
    cyc(0, SW, 6'b0, 0, 5, O_MWR, "rst_mw");
    cyc(1, SW, 6'b0, 1, 5, O_MWR, "rst_mw_assert");
    cyc(0, SW, 6'b0, 0, 0, O_FETCH, "rst_mw_after");

`ifdef ILLEGAL_OP_TRAP_EN
    cyc(0, BAD, 6'b0, 1, 0, O_FETCHR, "trap");
    cyc(0, BAD, 6'b0, 1, 1, O_DEC, "trap");
    for (int i = 0; i < 4; i++)
      cyc(0, BAD, 6'b0, 1, 12, O_HALT, "trap_halt");
    cyc(1, BAD, 6'b0, 1, 12, O_HALT, "trap_rst");
    cyc(0, RT, 6'b0, 0, 0, O_FETCH, "trap_after");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Sequencing controller for the multi-cycle MIPS datapath: one shared ALU, one shared instruction/data memory port, an instruction register (IR) and a PC register. It decodes Opcode/Funct from the IR and steps the datapath through fetch, decode, execute, memory and writeback states. It drives every datapath mux select and write enable each cycle, and handles a ready/request handshake with memory that includes a bounded wait timeout.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive wait cycles in a memory state before abort (1..255).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- Opcode  in  6  IR[31:26]; stable from the cycle after FETCH completes.
- Funct  in  6  IR[5:0].
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access request.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  store strobe.
- IRWrite  out  1  IR load enable.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  conditional PC load, gated by Zero in the datapath.
- PCSrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  out  3  ALU operation: 010 = add, 100 = sub, 110 = and, 101 = or.
- RegDst  out  1  write register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = memory data.
- RegWrite  out  1  register file write enable.
- BusErr  out  1  one-cycle pulse on memory timeout.
- State  out  4  current state encoding, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11, HALT 12.
- Output defaults: every output is 0 except ALUControl = 010. Each state lists only the outputs it changes.
- FETCH: MemReq = 1, ALUSrcB = 01, IRWrite = PCWrite = MemReady. Moves to DECODE on MemReady and holds otherwise.
- DECODE: ALUSrcB = 11 (precomputes the branch target). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEXEC
  - 000010 (j) → JUMP
  - any other opcode → see Configuration.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: MemReq = 1, IorD = 1. Moves to MEMWB on MemReady.
- MEMWB: MemtoReg = 1, RegWrite = 1. Returns to FETCH.
- MEMWRITE: MemReq = 1, IorD = 1, MemWrite = 1, all held through wait cycles. Moves to FETCH on MemReady.
- EXECUTE: ALUSrcA = 1, ALUSrcB = 00. ALUControl from Funct: 100000 → 010, 100010 → 100, 101010 → 110, 011100 → 101, any other Funct → 010. Moves to ALUWB.
- ALUWB: RegDst = 1, RegWrite = 1. Returns to FETCH.
- BRANCH: ALUSrcA = 1, ALUControl = 100, PCSrc = 01, Branch = 1. Returns to FETCH.
- ADDIEXEC: ALUSrcA = 1, ALUSrcB = 10. Moves to ADDIWB. ADDIWB: RegWrite = 1, then FETCH.
- JUMP: PCSrc = 10, PCWrite = 1. Returns to FETCH.
- Wait counter (8 bits): increments in FETCH, MEMREAD or MEMWRITE while MemReady = 0, and clears on any state change.
  - When the counter equals MEM_TIMEOUT and MemReady = 0: next state is FETCH and BusErr pulses high for one cycle. No write enable asserts during the abort.
  - MemReady = 1 in that same cycle wins: normal completion, no BusErr.

## Timing
- State is a registered Moore machine. Outputs are combinational from State, except IRWrite and PCWrite in FETCH, which also depend on MemReady (Mealy). BusErr is registered.
- Reset: State = FETCH, counter = 0, BusErr = 0. Outputs in the first cycle after reset: MemReq = 1, ALUSrcB = 01, ALUControl = 010, all others 0 (given MemReady = 0).
- Asserting rst mid-instruction aborts it. The next state is FETCH regardless of MemReady; no further enables from the aborted instruction.
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each memory wait adds one cycle.

## Configuration
- ILLEGAL_OP_TRAP_EN defined: an unknown opcode in DECODE moves to HALT. HALT drives all defaults, sets MemReq = 0, and holds until rst.
- ILLEGAL_OP_TRAP_EN undefined: an unknown opcode moves from DECODE to FETCH with no writes (treated as a NOP, 2 cycles). HALT is unreachable.

## Test plan
- R-type add (Opcode 000000, Funct 100000), MemReady = 1 → State 0,1,6,7,0. ALUControl = 010 in EXECUTE; RegDst = RegWrite = 1 only in ALUWB.
- lw with MemReady low for 3 cycles in MEMREAD → State holds 3 for 4 cycles; MemReq = IorD = 1 throughout; RegWrite pulses once in MEMWB.
- beq (000100) → BRANCH shows ALUControl = 100, PCSrc = 01, Branch = 1 for exactly one cycle; j → JUMP shows PCWrite = 1, PCSrc = 10.
- FETCH with MemReady = 0 for MEM_TIMEOUT + 1 cycles, MEM_TIMEOUT = 15 → BusErr high for 1 cycle, IRWrite never asserted, State = 0.
- rst asserted while in MEMWRITE → next cycle State = 0, MemWrite = 0, BusErr = 0.
- Opcode 111111 → with ILLEGAL_OP_TRAP_EN: State = 12, MemReq = 0 until rst. Without it: returns to State 0 after DECODE, no RegWrite or MemWrite.
